// File: rtl/gpr_file_mp.sv
// gpr_file_mp: multi-port register file with dual byte-masked writes, write-to-read bypass and busy scoreboard
module gpr_file_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int BW      = DW / 8,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic [1:0]           wr_en,
    input  logic [2*AW-1:0]      wr_addr,
    input  logic [2*DW-1:0]      wr_data,
    input  logic [2*BW-1:0]      wr_be,
    input  logic                 busy_set,
    input  logic [AW-1:0]        busy_addr,
    output logic [CW-1:0]        busy_cnt
);
    localparam bit ZR = ZERO_REG != 0;
    logic [DEPTH-1:0][DW-1:0] mem, nxt;
    logic [DEPTH-1:0]         busy, busy_nxt, set, clr;
    logic [CW-1:0]            cnt_nxt;
    for (genvar a = 0; a < DEPTH; a++) begin : g_reg
        logic h0, h1;
        assign h0 = wr_en[0] && wr_addr[0 +: AW] == AW'(a);
        assign h1 = wr_en[1] && wr_addr[AW +: AW] == AW'(a);
        assign clr[a] = h0 || h1;
        assign set[a] = busy_set && busy_addr == AW'(a) && !(ZR && a == 0);
        assign busy_nxt[a] = set[a] || (busy[a] && !clr[a]);
        for (genvar b = 0; b < BW; b++) begin : g_byte
            assign nxt[a][8*b +: 8] = (ZR && a == 0) ? 8'h00 :
                                      (h1 && wr_be[BW+b]) ? wr_data[DW+8*b +: 8] :
                                      (h0 && wr_be[b])    ? wr_data[8*b +: 8] :
                                      mem[a][8*b +: 8];
        end
    end
    always_comb begin
        cnt_nxt = '0;
        for (int a = 0; a < DEPTH; a++) cnt_nxt += CW'(busy_nxt[a]);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem      <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            mem      <= nxt;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[i*AW +: AW];
        assign rd_data[i*DW +: DW] = !reset ? '0 : (BYPASS != 0) ? nxt[ra] : mem[ra];
        assign rd_busy[i] = reset && busy[ra] && (BYPASS == 0 || set[ra] || !clr[ra]);
    end
endmodule
